// File: rtl/mc6845_init_sequencer_if.sv
// CRTC processor-bus pins (E, CSn, RS, RW, D) driven by the init sequencer.
interface mc6845_init_sequencer_if;
    logic       E;
    logic       CSn;
    logic       RS;
    logic       RW;
    logic [7:0] D;

    modport master (output E, CSn, RS, RW, D);
    modport slave  (input  E, CSn, RS, RW, D);
endinterface

// File: rtl/mc6845_init_sequencer.sv
// MC6845 CRTC bus master: programs R0..R(NUM_REGS-1) from an MDA/CGA table and writes cursor R14/R15.
// Optional MC6845_INIT_SEQ_CURSOR_VSYNC_EN defers accepted cursor writes to the next VSYNC rising edge.
module mc6845_init_sequencer #(
    parameter int E_HIGH_CYCLES = 2,
    parameter int NUM_REGS      = 16
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic                           start,
    input  logic                           mode,
    input  logic                           cur_req,
    input  logic [13:0]                    cur_addr,
    input  logic                           vsync,
    output logic                           cur_ack,
    output logic                           busy,
    output logic                           done,
    mc6845_init_sequencer_if.master        crtc
);

    typedef enum logic [3:0] {
        IDLE, ADDR_SETUP, ADDR_E, ADDR_HOLD, DATA_SETUP, DATA_E, DATA_HOLD, NEXT
`ifdef MC6845_INIT_SEQ_CURSOR_VSYNC_EN
        , WAIT_VS
`endif
    } state_t;

    localparam logic [7:0] MDA_TBL [16] = '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19,
                                            8'h02, 8'h0D, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] CGA_TBL [16] = '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                                            8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [3:0] E_LAST   = 4'(E_HIGH_CYCLES - 1);

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  ecnt;
    logic        in_init;
    logic        tbl_mode;
    logic        start_pend;
    logic        start_pend_n;
    logic [13:0] cur_q;
    logic        e_q, csn_q, rs_q;
    logic [7:0]  d_q;
    logic        arb, take_init, take_cur, last;
    logic [7:0]  reg_val;

    assign crtc.E   = e_q;
    assign crtc.CSn = csn_q;
    assign crtc.RS  = rs_q;
    assign crtc.RW  = 1'b0;
    assign crtc.D   = d_q;

    // NEXT arbitrates like IDLE so queued work follows without dropping busy.
    assign arb       = (state == IDLE) || (state == NEXT);
    assign take_init = arb && (start || start_pend);
    assign take_cur  = arb && !start && !start_pend && cur_req;
    assign cur_ack   = take_cur;

    assign last    = in_init ? (idx == LAST_IDX) : (idx == 4'd15);
    assign reg_val = in_init ? (tbl_mode ? CGA_TBL[idx] : MDA_TBL[idx])
                             : (idx[0] ? cur_q[7:0] : {2'b00, cur_q[13:8]});

    // A start during an init pass is dropped; during cursor work it waits.
    always_comb begin
        start_pend_n = start_pend;
        if (take_init)
            start_pend_n = 1'b0;
        else if (start && !arb && !in_init)
            start_pend_n = 1'b1;
    end

`ifdef MC6845_INIT_SEQ_CURSOR_VSYNC_EN
    logic vs_s1, vs_s2, vs_q, vs_rise;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_q  <= vs_s2;
        end
    end

    assign vs_rise = vs_s2 && !vs_q;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            idx        <= '0;
            ecnt       <= '0;
            in_init    <= 1'b0;
            tbl_mode   <= 1'b0;
            start_pend <= 1'b0;
            cur_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            e_q        <= 1'b0;
            csn_q      <= 1'b1;
            rs_q       <= 1'b0;
            d_q        <= '0;
        end else begin
            done       <= 1'b0;
            start_pend <= start_pend_n;
            case (state)
                IDLE, NEXT: begin
                    e_q   <= 1'b0;
                    csn_q <= 1'b1;
                    rs_q  <= 1'b0;
                    d_q   <= '0;
                    if (take_init) begin
                        in_init  <= 1'b1;
                        tbl_mode <= mode;
                        idx      <= '0;
                        busy     <= 1'b1;
                        csn_q    <= 1'b0;
                        state    <= ADDR_SETUP;
                    end else if (take_cur) begin
                        in_init <= 1'b0;
                        cur_q   <= cur_addr;
                        idx     <= 4'd14;
                        busy    <= 1'b1;
`ifdef MC6845_INIT_SEQ_CURSOR_VSYNC_EN
                        state   <= WAIT_VS;
`else
                        csn_q   <= 1'b0;
                        d_q     <= 8'h0E;
                        state   <= ADDR_SETUP;
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`ifdef MC6845_INIT_SEQ_CURSOR_VSYNC_EN
                WAIT_VS: begin
                    if (vs_rise) begin
                        csn_q <= 1'b0;
                        rs_q  <= 1'b0;
                        d_q   <= {4'b0000, idx};
                        state <= ADDR_SETUP;
                    end
                end
`endif
                ADDR_SETUP: begin
                    e_q   <= 1'b1;
                    ecnt  <= '0;
                    state <= ADDR_E;
                end
                ADDR_E: begin
                    if (ecnt == E_LAST) begin
                        e_q   <= 1'b0;
                        state <= ADDR_HOLD;
                    end else begin
                        ecnt <= ecnt + 4'd1;
                    end
                end
                ADDR_HOLD: begin
                    rs_q  <= 1'b1;
                    d_q   <= reg_val;
                    state <= DATA_SETUP;
                end
                DATA_SETUP: begin
                    e_q   <= 1'b1;
                    ecnt  <= '0;
                    state <= DATA_E;
                end
                DATA_E: begin
                    if (ecnt == E_LAST) begin
                        e_q   <= 1'b0;
                        state <= DATA_HOLD;
                    end else begin
                        ecnt <= ecnt + 4'd1;
                    end
                end
                DATA_HOLD: begin
                    if (!last) begin
                        idx   <= idx + 4'd1;
                        rs_q  <= 1'b0;
                        d_q   <= {4'b0000, idx + 4'd1};
                        state <= ADDR_SETUP;
                    end else begin
                        // busy only survives into NEXT if more work is already waiting
                        csn_q <= 1'b1;
                        rs_q  <= 1'b0;
                        d_q   <= '0;
                        done  <= in_init;
                        busy  <= start_pend_n || cur_req;
                        state <= NEXT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc6845_init_sequencer.sv
// Directed bench for mc6845_init_sequencer: reset, MDA/CGA init passes, cursor writes, arbitration, reset abort.
module tb_mc6845_init_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        cur_req = 1'b0;
    logic [13:0] cur_addr = '0;
    logic        vsync = 1'b0;
    logic        cur_ack, busy, done;

    int          errs = 0;
    int          checks = 0;
    logic [8:0]  mon_q [$];

    localparam logic [7:0] MDA [16] = '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19,
                                        8'h02, 8'h0D, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00};

    mc6845_init_sequencer_if crtc_bus();

    mc6845_init_sequencer #(.E_HIGH_CYCLES(2), .NUM_REGS(16)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .start   (start),
        .mode    (mode),
        .cur_req (cur_req),
        .cur_addr(cur_addr),
        .vsync   (vsync),
        .cur_ack (cur_ack),
        .busy    (busy),
        .done    (done),
        .crtc    (crtc_bus)
    );

    always #5 CLK = ~CLK;

    // bus monitor: the CRTC latches {RS, D} on each falling edge of E
    always @(negedge crtc_bus.E) if (RSTn) mon_q.push_back({crtc_bus.RS, crtc_bus.D});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_pair(input string tag, input int k, input logic rs, input logic [7:0] d);
        logic [8:0] e;
        e = {rs, d};
        chk(tag, (k < mon_q.size()) ? 32'(mon_q[k]) : 32'hDEAD, 32'(e));
    endtask

    // Cycle 0 is the current negedge; stimulus is applied first, outputs sampled 1ns later.
    task automatic watch(input int n, input logic m, input int st_at, input int st2_at,
                         input int req_at, input logic [13:0] addr,
                         output int nb, output int fl, output int da, output int nd,
                         output int aa, output int na);
        bit seen;
        nb = 0; fl = -1; da = -1; nd = 0; aa = -1; na = 0; seen = 0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) @(negedge CLK);
            if (i == st_at + 1 || i == st2_at + 1) start = 1'b0;
            if (aa >= 0 && i > aa) cur_req = 1'b0;
            if (i == st_at || i == st2_at) begin mode = m; start = 1'b1; end
            if (i == req_at) begin cur_addr = addr; cur_req = 1'b1; end
            #1;
            if (cur_ack) begin na++; if (aa < 0) aa = i; end
            if (busy) begin nb++; seen = 1; end
            else if (seen && fl < 0) fl = i;
            if (done) begin nd++; if (da < 0) da = i; end
        end
    endtask

    initial begin
        int nb, fl, da, nd, aa, na, ndata;
        logic [13:0] a;

        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_E", crtc_bus.E, 0);
        chk("rst_CSn", crtc_bus.CSn, 1);
        chk("rst_RS", crtc_bus.RS, 0);
        chk("rst_RW", crtc_bus.RW, 0);
        chk("rst_D", crtc_bus.D, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", cur_ack, 0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // init pass, MDA table
        mon_q.delete();
        watch(160, 1'b0, 0, -1, -1, 14'h0, nb, fl, da, nd, aa, na);
        chk("m0_busy_cycles", nb, 128);
        chk("m0_busy_fall", fl, 129);
        chk("m0_done_at", da, 129);
        chk("m0_done_cnt", nd, 1);
        chk("m0_e_falls", mon_q.size(), 32);
        for (int k = 0; k < 16; k++) begin
            chk_pair("m0_addr", 2 * k, 1'b0, 8'(k));
            chk_pair("m0_data", 2 * k + 1, 1'b1, MDA[k]);
        end

        // init pass, CGA table, with phase-level timing of the first address write
        mon_q.delete();
        @(negedge CLK); mode = 1'b1; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        chk("c1_setup_CSn", crtc_bus.CSn, 0);
        chk("c1_setup_E", crtc_bus.E, 0);
        chk("c1_busy", busy, 1);
        chk("c1_RW", crtc_bus.RW, 0);
        @(negedge CLK);
        chk("c2_E", crtc_bus.E, 1);
        @(negedge CLK);
        chk("c3_E", crtc_bus.E, 1);
        @(negedge CLK);
        chk("c4_hold_E", crtc_bus.E, 0);
        chk("c4_hold_CSn", crtc_bus.CSn, 0);
        chk("c4_hold_RS", crtc_bus.RS, 0);
        @(negedge CLK);
        chk("c5_data_RS", crtc_bus.RS, 1);
        chk("c5_data_D", crtc_bus.D, 8'h71);
        repeat (130) @(negedge CLK);
        chk("m1_busy_end", busy, 0);
        chk("m1_e_falls", mon_q.size(), 32);
        chk_pair("m1_R0", 1, 1'b1, 8'h71);
        chk_pair("m1_R2", 5, 1'b1, 8'h5A);
        chk_pair("m1_R9", 19, 1'b1, 8'h07);
        ndata = 0;
        foreach (mon_q[k]) if (mon_q[k][8]) ndata++;
        chk("m1_writes", ndata, 16);

        // start during an init pass is dropped
        mon_q.delete();
        watch(160, 1'b0, 0, 50, -1, 14'h0, nb, fl, da, nd, aa, na);
        chk("ign_busy_cycles", nb, 128);
        chk("ign_done_cnt", nd, 1);
        chk("ign_e_falls", mon_q.size(), 32);

`ifndef MC6845_INIT_SEQ_CURSOR_VSYNC_EN
        // cursor write from IDLE
        mon_q.delete();
        a = 14'h3A5C;
        watch(30, 1'b0, -1, -1, 0, a, nb, fl, da, nd, aa, na);
        chk("cur_ack_at", aa, 0);
        chk("cur_ack_cnt", na, 1);
        chk("cur_busy_cycles", nb, 16);
        chk("cur_busy_fall", fl, 17);
        chk("cur_no_done", nd, 0);
        chk("cur_e_falls", mon_q.size(), 4);
        chk_pair("cur_a14", 0, 1'b0, 8'h0E);
        chk_pair("cur_d14", 1, 1'b1, {2'b00, a[13:8]});
        chk_pair("cur_a15", 2, 1'b0, 8'h0F);
        chk_pair("cur_d15", 3, 1'b1, a[7:0]);

        // cursor request raised mid-pass waits for done, then follows back-to-back
        mon_q.delete();
        a = 14'h0123;
        watch(170, 1'b0, 0, -1, 10, a, nb, fl, da, nd, aa, na);
        chk("mix_done_at", da, 129);
        chk("mix_ack_at", aa, 129);
        chk("mix_ack_cnt", na, 1);
        chk("mix_busy_cycles", nb, 145);
        chk("mix_busy_fall", fl, 146);
        chk("mix_e_falls", mon_q.size(), 36);
        chk_pair("mix_d14", 33, 1'b1, 8'h01);
        chk_pair("mix_d15", 35, 1'b1, 8'h23);

        // start during a cursor write is held and runs afterwards
        mon_q.delete();
        a = 14'h0555;
        watch(170, 1'b0, 3, -1, 0, a, nb, fl, da, nd, aa, na);
        chk("pend_ack_at", aa, 0);
        chk("pend_busy_cycles", nb, 145);
        chk("pend_busy_fall", fl, 146);
        chk("pend_done_at", da, 146);
        chk("pend_e_falls", mon_q.size(), 36);
        chk_pair("pend_d14", 1, 1'b1, 8'h05);
        chk_pair("pend_d15", 3, 1'b1, 8'h55);
        chk_pair("pend_R0", 5, 1'b1, 8'h61);
`else
        // cursor write deferred to the VSYNC rising edge
        begin
            int hit;
            mon_q.delete();
            @(negedge CLK); cur_addr = 14'h3A5C; cur_req = 1'b1;
            #1 chk("vs_ack", cur_ack, 1);
            @(negedge CLK); cur_req = 1'b0;
            repeat (20) @(negedge CLK);
            chk("vs_wait_busy", busy, 1);
            chk("vs_wait_quiet", mon_q.size(), 0);
            vsync = 1'b1;
            hit = -1;
            for (int j = 1; j <= 8; j++) begin
                @(negedge CLK);
                if (!crtc_bus.CSn && hit < 0) hit = j;
            end
            chk("vs_setup_delay", hit, 3);
            repeat (20) @(negedge CLK);
            vsync = 1'b0;
            chk("vs_e_falls", mon_q.size(), 4);
            chk("vs_busy_end", busy, 0);
        end
`endif

        // reset during DATA_E of R5 abandons the pass
        mon_q.delete();
        @(negedge CLK); mode = 1'b0; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (45) @(negedge CLK);
        chk("r5_E", crtc_bus.E, 1);
        chk("r5_D", crtc_bus.D, 8'h06);
        RSTn = 1'b0;
        #1;
        chk("abort_E", crtc_bus.E, 0);
        chk("abort_CSn", crtc_bus.CSn, 1);
        chk("abort_busy", busy, 0);
        chk("abort_e_falls", mon_q.size(), 11);
        for (int j = 0; j < 3; j++) begin
            @(negedge CLK);
            chk("abort_no_done", done, 0);
        end
        RSTn = 1'b1;
        @(negedge CLK);
        chk("post_rst_done", done, 0);
        mon_q.delete();
        watch(160, 1'b0, 0, -1, -1, 14'h0, nb, fl, da, nd, aa, na);
        chk("rerun_busy_cycles", nb, 128);
        chk("rerun_done_at", da, 129);
        chk("rerun_e_falls", mon_q.size(), 32);
        chk_pair("rerun_a0", 0, 1'b0, 8'h00);
        chk_pair("rerun_R0", 1, 1'b1, 8'h61);
        chk_pair("rerun_R5", 11, 1'b1, 8'h06);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
